// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one ALU between two requesters. It accepts one
// operation at a time, waits out the ALU latency, and returns the tagged result.
module alu_rr_arbiter #(
    parameter int WIDTH   = 32,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result
);

    // A 4-bit counter covers the whole legal latency range of 0..15.
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic [CNT_W-1:0] wait_cnt;

    logic grant0;
    logic grant1;
    logic accept;
    logic accept_id;
    logic capture;
    logic rsp_done;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign accept_id  = req1_ready;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ALU operands hold their last accepted values; they only move on an accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
        end else if (accept) begin
            alu_a      <= accept_id ? req1_a  : req0_a;
            alu_b      <= accept_id ? req1_b  : req0_b;
            alu_op     <= accept_id ? req1_op : req0_op;
            last_grant <= accept_id;
            wait_cnt   <= LAT_LOAD;
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Response channel: reset discards any held response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
        end else begin
            if (accept) begin
                rsp_id <= accept_id;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_valid  <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: directed operations with hand-computed XOR
// results, a queue-fed requester driver and an independent response monitor.
module tb_alu_rr_arbiter;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } op_t;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        rsp_valid, rsp_id;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;

    // Second instance built with a combinational ALU
    logic        req0_valid_z = 1'b0, req1_valid_z = 1'b0;
    logic        req0_ready_z, req1_ready_z;
    logic [31:0] req0_a_z = '0, req0_b_z = '0;
    logic [3:0]  req0_op_z = '0;
    logic [31:0] alu_a_z, alu_b_z, alu_result_z;
    logic [3:0]  alu_op_z;
    logic        rsp_valid_z, rsp_id_z;
    logic        rsp_ready_z = 1'b1;
    logic [31:0] rsp_result_z;

    op_t  q0[$];
    op_t  q1[$];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.WIDTH(32), .OPW(4), .ALU_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
    );

    alu_rr_arbiter #(.WIDTH(32), .OPW(4), .ALU_LAT(0)) dut0 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid_z), .req0_ready(req0_ready_z), .req0_a(req0_a_z), .req0_b(req0_b_z), .req0_op(req0_op_z),
        .req1_valid(req1_valid_z), .req1_ready(req1_ready_z), .req1_a(32'h0), .req1_b(32'h0), .req1_op(4'h0),
        .alu_a(alu_a_z), .alu_b(alu_b_z), .alu_op(alu_op_z), .alu_result(alu_result_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_id(rsp_id_z), .rsp_result(rsp_result_z)
    );

    // ALU stubs: XOR with one cycle of latency, and a combinational XOR
    always @(posedge clk) alu_result <= alu_a ^ alu_b;
    assign alu_result_z = alu_a_z ^ alu_b_z;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Requester driver: presents queued operations, advancing after each accept
    initial begin
        bit  acc0, acc1;
        op_t o;
        forever begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready && !reset;
            acc1 = req1_valid && req1_ready && !reset;
            @(posedge clk);
            #1;
            if (acc0 || !req0_valid) begin
                if (q0.size() > 0) begin
                    o = q0.pop_front();
                    req0_valid = 1'b1; req0_a = o.a; req0_b = o.b; req0_op = o.op;
                end else begin
                    req0_valid = 1'b0;
                end
            end
            if (acc1 || !req1_valid) begin
                if (q1.size() > 0) begin
                    o = q1.pop_front();
                    req1_valid = 1'b1; req1_a = o.a; req1_b = o.b; req1_op = o.op;
                end else begin
                    req1_valid = 1'b0;
                end
            end
        end
    end

    // Response monitor: every completed handshake must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready && !reset) begin
                check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_result", 64'(rsp_result), 64'(e.res));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got no end, want end");
        $fatal(1, "timeout");
    end

    task automatic push(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] res);
        op_t  o;
        exp_t e;
        o = '{a: a, b: b, op: op};
        e = '{id: id, res: res};
        if (id) q1.push_back(o);
        else    q0.push_back(o);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
                 !req0_valid && !req1_valid && !rsp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < budget), 64'd1);
    endtask

    initial begin
        bit seen;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_state", 64'(dut1.state), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);

        // Single request with cycle-accurate timing
        push(1'b0, 32'h0000001B, 32'h0000002E, 4'b0100, 32'h00000035);
        @(posedge clk); #2;
        @(negedge clk);                               // before accept edge
        check("single_ready", 64'(req0_ready), 64'd1);
        @(negedge clk);                               // 1 after accept
        check("single_ready_drop", 64'(req0_ready), 64'd0);
        check("single_alu_op", 64'(alu_op), 64'h4);
        check("single_alu_a", 64'(alu_a), 64'h1B);
        check("single_alu_b", 64'(alu_b), 64'h2E);
        check("single_rsp_early1", 64'(rsp_valid), 64'd0);
        @(negedge clk);                               // 2 after accept edge is next
        check("single_rsp_early2", 64'(rsp_valid), 64'd0);
        check("single_alu_hold", 64'(alu_op), 64'h4);
        @(negedge clk);
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        check("single_rsp_id", 64'(rsp_id), 64'd0);
        check("single_rsp_result", 64'(rsp_result), 64'h35);
        @(negedge clk);
        check("single_idle", 64'(dut1.state), 64'd0);
        check("single_rsp_clear", 64'(rsp_valid), 64'd0);

        // Reset while the operation is waiting on the ALU
        q0.push_back('{a: 32'h00000005, b: 32'h00000003, op: 4'h9});
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = req0_ready;
        end
        check("rstmid_accept_seen", 64'(seen), 64'd1);
        @(posedge clk); #2;
        check("rstmid_in_wait", 64'(dut1.state), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_state", 64'(dut1.state), 64'd0);
        check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rstmid_alu_a", 64'(alu_a), 64'd0);
        check("rstmid_alu_b", 64'(alu_b), 64'd0);
        check("rstmid_alu_op", 64'(alu_op), 64'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check("rstmid_no_rsp", 64'(seen), 64'd0);

        // First tie after reset: requester 0 first, then requester 1
        push(1'b0, 32'h0000FF00, 32'h00FF00FF, 4'h1, 32'h00FFFFFF);
        push(1'b1, 32'h00000012, 32'h00000034, 4'h2, 32'h00000026);
        wait_drain("tie_drain", 40);

        // Continuous contention: strict alternation 0,1,0,1,0,1
        push(1'b0, 32'h00000011, 32'h00000022, 4'h3, 32'h00000033);
        push(1'b1, 32'h00000001, 32'h00000002, 4'h4, 32'h00000003);
        push(1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'h5, 32'hFFFFFFFF);
        push(1'b1, 32'hA5A5A5A5, 32'h5A5A0000, 4'h6, 32'hFFFFA5A5);
        push(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h7, 32'h00000000);
        push(1'b1, 32'h80000000, 32'h00000001, 4'h8, 32'h80000001);
        wait_drain("contend_drain", 100);

        // Backpressure: response must hold for 5 cycles while nothing else is accepted
        rsp_ready = 1'b0;
        push(1'b0, 32'h12345678, 32'h0F0F0F0F, 4'hA, 32'h1D3B5977);
        push(1'b1, 32'h00000001, 32'hFFFFFFFF, 4'hB, 32'hFFFFFFFE);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_seen", 64'(n < 20), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_id", 64'(rsp_id), 64'd0);
            check("bp_result", 64'(rsp_result), 64'h1D3B5977);
            check("bp_ready0", 64'(req0_ready), 64'd0);
            check("bp_ready1", 64'(req1_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_done", 64'(rsp_valid), 64'd0);
        wait_drain("bp_drain", 40);

        // Combinational-ALU build: response one cycle after accept
        @(posedge clk); #1;
        req0_valid_z = 1'b1; req0_a_z = 32'h0000001B; req0_b_z = 32'h0000002E; req0_op_z = 4'b0100;
        @(negedge clk);
        check("lat0_ready", 64'(req0_ready_z), 64'd1);
        @(posedge clk); #1;
        req0_valid_z = 1'b0;
        @(negedge clk);
        check("lat0_alu_op", 64'(alu_op_z), 64'h4);
        check("lat0_rsp_early", 64'(rsp_valid_z), 64'd0);
        @(negedge clk);
        check("lat0_rsp_valid", 64'(rsp_valid_z), 64'd1);
        check("lat0_rsp_id", 64'(rsp_id_z), 64'd0);
        check("lat0_rsp_result", 64'(rsp_result_z), 64'h35);
        @(negedge clk);
        check("lat0_rsp_clear", 64'(rsp_valid_z), 64'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
